// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART TX sequencer.
//   - Register-bus address map of the UART peripheral.
//   - Enable-register values.
//   - FSM state encoding.
// Build option: UART_SEQ_RX_POLL_EN adds the RX_RD state used for RX polling.
package uart_pkg;

  localparam logic [1:0] ADDR_BAUD_DATA = 2'd0;
  localparam logic [1:0] ADDR_ENABLE    = 2'd1;
  localparam logic [1:0] ADDR_TX_DATA   = 2'd2;
  localparam logic [1:0] ADDR_RX_DATA   = 2'd3;

  localparam logic [7:0] ENABLE_ON  = 8'h01;
  localparam logic [7:0] ENABLE_OFF = 8'h00;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG_BAUD = 3'd1,
    CFG_EN   = 3'd2,
    READY    = 3'd3,
    WR_TX    = 3'd4,
    GAP      = 3'd5,
    DIS      = 3'd6
`ifdef UART_SEQ_RX_POLL_EN
    ,RX_RD   = 3'd7
`endif
  } seq_state_e;

endpackage

// File: rtl/uart_seq_fifo.sv
// uart_seq_fifo: byte FIFO that holds TX data for the sequencer.
// Ports:
//   clk, rst (async, active-low)
//   push, push_data : write request; ignored while full
//   pop             : read request; ignored while empty
//   full, empty     : occupancy flags (registered count, no bypass)
//   head            : oldest entry, valid while !empty
// Parameter FIFO_DEPTH must be a power of two >= 2 so pointers wrap naturally.
module uart_seq_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Push is qualified by the registered full flag, so a slot freed by a pop
  // in the same cycle only becomes usable one cycle later.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: configures a UART over its register bus, streams queued
// bytes to the TX data register with a programmable inter-byte gap, and
// disables the UART once a stop request has drained the FIFO.
// Ports:
//   clk, rst (async, active-low)
//   start, stop        : session control pulses
//   baud_div           : value written to the baud register during config
//   frame_cycles       : clocks to wait after each TX write (0 acts as 1)
//   push_valid/data/ready : byte producer handshake into the TX FIFO
//   address, write_data, we, re, read_data : UART register-bus master
//   busy               : high whenever a session is active
//   rx_data, rx_valid  : last polled RX byte and its one-cycle strobe
// Build option: UART_SEQ_RX_POLL_EN enables RX polling when the FIFO is idle;
// without it re, rx_data and rx_valid are tied low.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | no session; waiting for start
// CFG_BAUD | writing baud_div to the baud register
// CFG_EN   | writing 1 to the enable register
// READY    | choosing: send byte, disable, or poll RX
// WR_TX    | writing the FIFO head to the TX data register
// GAP      | counting down the inter-byte gap
// DIS      | writing 0 to the enable register, then IDLE
// RX_RD    | reading the RX data register (poll build only)
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       baud_div,
  input  logic [GAP_W-1:0] frame_cycles,
  input  logic             push_valid,
  input  logic [7:0]       push_data,
  output logic             push_ready,
  output logic [1:0]       address,
  output logic [7:0]       write_data,
  output logic             we,
  output logic             re,
  input  logic [7:0]       read_data,
  output logic             busy,
  output logic [7:0]       rx_data,
  output logic             rx_valid
);

  seq_state_e       state_q, state_d;
  logic             stop_pend_q, stop_pend_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       address_q, address_d;
  logic [7:0]       write_data_q, write_data_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic             busy_q, busy_d;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;

  uart_seq_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign push_ready = !fifo_full;

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q | (stop && (state_q != IDLE));
    gap_d       = gap_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = CFG_BAUD;
      CFG_BAUD: state_d = CFG_EN;
      CFG_EN:   state_d = READY;
      READY: begin
        if (!fifo_empty) begin
          // Pop on entry to WR_TX; the head is captured into write_data
          // on the same edge.
          state_d  = WR_TX;
          fifo_pop = 1'b1;
        end else if (stop_pend_q) begin
          state_d = DIS;
`ifdef UART_SEQ_RX_POLL_EN
        end else begin
          state_d = RX_RD;
`endif
        end
      end
      WR_TX: begin
        gap_d   = (frame_cycles == '0) ? '0 : frame_cycles - GAP_W'(1);
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == '0) state_d = READY;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      DIS: begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
      end
`ifdef UART_SEQ_RX_POLL_EN
      RX_RD:    state_d = READY;
`endif
      default:  state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so they line
  // up with the state register and never combinationally follow an input.
  always_comb begin
    address_d    = '0;
    write_data_d = '0;
    we_d         = 1'b0;
    re_d         = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_d)
      CFG_BAUD: begin
        address_d    = ADDR_BAUD_DATA;
        write_data_d = baud_div;
        we_d         = 1'b1;
      end
      CFG_EN: begin
        address_d    = ADDR_ENABLE;
        write_data_d = ENABLE_ON;
        we_d         = 1'b1;
      end
      WR_TX: begin
        address_d    = ADDR_TX_DATA;
        write_data_d = fifo_head;
        we_d         = 1'b1;
      end
      DIS: begin
        address_d    = ADDR_ENABLE;
        write_data_d = ENABLE_OFF;
        we_d         = 1'b1;
      end
`ifdef UART_SEQ_RX_POLL_EN
      RX_RD: begin
        address_d = ADDR_RX_DATA;
        re_d      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      stop_pend_q  <= 1'b0;
      gap_q        <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stop_pend_q  <= stop_pend_d;
      gap_q        <= gap_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      we_q         <= we_d;
      re_q         <= re_d;
      busy_q       <= busy_d;
    end
  end

  assign address    = address_q;
  assign write_data = write_data_q;
  assign we         = we_q;
  assign busy       = busy_q;

`ifdef UART_SEQ_RX_POLL_EN
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;

  // read_data is sampled at the edge that ends the re cycle.
  always_comb begin
    rx_valid_d = (state_q == RX_RD);
    rx_data_d  = (state_q == RX_RD) ? read_data : rx_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign re       = re_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  logic unused_rx;
  assign unused_rx = ^{read_data, re_q};
  assign re        = 1'b0;
  assign rx_data   = '0;
  assign rx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: self-checking bench for uart_tx_sequencer.
// Build option: UART_SEQ_RX_POLL_EN selects the RX polling checks.
module tb_uart_tx_sequencer;
  localparam int DEPTH = 4;
  localparam int GW    = 16;

  logic          clk;
  logic          rst;
  logic          start, stop;
  logic [7:0]    baud_div;
  logic [GW-1:0] frame_cycles;
  logic          push_valid;
  logic [7:0]    push_data;
  logic          push_ready;
  logic [1:0]    address;
  logic [7:0]    write_data;
  logic          we, re;
  logic [7:0]    read_data;
  logic          busy;
  logic [7:0]    rx_data;
  logic          rx_valid;

  uart_tx_sequencer #(.FIFO_DEPTH(DEPTH), .GAP_W(GW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .baud_div     (baud_div),
    .frame_cycles (frame_cycles),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .address      (address),
    .write_data   (write_data),
    .we           (we),
    .re           (re),
    .read_data    (read_data),
    .busy         (busy),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int re_cnt = 0;

  logic [1:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         wr_cyc  [$];
  logic [7:0] tx_data [$];
  int         tx_cyc  [$];
  logic [7:0] model_q [$];

  typedef struct {
    logic [GW-1:0] fc;
    logic [7:0]    b0;
    logic [7:0]    b1;
    int            exp_spacing;
  } vec_t;
  vec_t vecs [4];

  // Advance to the next falling edge and record every bus access seen there.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (we === 1'b1) begin
      wr_addr.push_back(address);
      wr_data.push_back(write_data);
      wr_cyc.push_back(cyc);
      if (address == 2'd2) begin
        tx_data.push_back(write_data);
        tx_cyc.push_back(cyc);
      end
    end
    if (re === 1'b1) re_cnt++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_valid = 1'b1;
    push_data  = b;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    chk("wait_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_tx(input int target, input int bound);
    int n = 0;
    while (tx_data.size() < target && n < bound) begin
      tick();
      n++;
    end
    chk("wait_tx", tx_data.size(), target);
  endtask

  initial begin
    int base;
    int wbase;
    int acc;
    int occ;
    logic [7:0] bytes5 [5];

    vecs[0] = '{fc: 16'd5, b0: 8'h55, b1: 8'hAA, exp_spacing: 7};
    vecs[1] = '{fc: 16'd0, b0: 8'h12, b1: 8'h34, exp_spacing: 3};
    vecs[2] = '{fc: 16'd1, b0: 8'hC3, b1: 8'h3C, exp_spacing: 3};
    vecs[3] = '{fc: 16'd2, b0: 8'hF0, b1: 8'h0F, exp_spacing: 4};

    rst = 1'b0; start = 1'b0; stop = 1'b0; baud_div = 8'h00;
    frame_cycles = '0; push_valid = 1'b0; push_data = 8'h00; read_data = 8'h3C;

    // Reset values
    tick(); tick();
    chk("rst_we", {31'b0, we}, 0);
    chk("rst_re", {31'b0, re}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_addr", {30'b0, address}, 0);
    chk("rst_wdata", {24'b0, write_data}, 0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 0);
    chk("rst_rx_data", {24'b0, rx_data}, 0);
    chk("rst_push_ready", {31'b0, push_ready}, 1);
    rst = 1'b1;
    tick();

    // Configuration writes
    baud_div = 8'h1A;
    start_pulse();
    chk("cfg_baud_we", {31'b0, we}, 1);
    chk("cfg_baud_addr", {30'b0, address}, 0);
    chk("cfg_baud_data", {24'b0, write_data}, 32'h1A);
    chk("cfg_busy", {31'b0, busy}, 1);
    tick();
    chk("cfg_en_we", {31'b0, we}, 1);
    chk("cfg_en_addr", {30'b0, address}, 1);
    chk("cfg_en_data", {24'b0, write_data}, 32'h01);
    tick();
    chk("ready_we", {31'b0, we}, 0);
`ifdef UART_SEQ_RX_POLL_EN
    begin
      int n = 0;
      while (re !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("rx_re", {31'b0, re}, 1);
    chk("rx_addr", {30'b0, address}, 3);
    tick();
    chk("rx_valid", {31'b0, rx_valid}, 1);
    chk("rx_data", {24'b0, rx_data}, 32'h3C);
`endif
    stop_pulse();
    wait_idle(50);
    chk("dis_addr", {30'b0, wr_addr[wr_addr.size()-1]}, 1);
    chk("dis_data", {24'b0, wr_data[wr_data.size()-1]}, 0);

    // Table: two bytes per session, gap spacing vs frame_cycles
    for (int v = 0; v < 4; v++) begin
      frame_cycles = vecs[v].fc;
      base = tx_data.size();
      push_byte(vecs[v].b0);
      push_byte(vecs[v].b1);
      start_pulse();
      wait_tx(base + 2, 100);
      if (tx_data.size() >= base + 2) begin
        chk("vec_b0", {24'b0, tx_data[base]}, {24'b0, vecs[v].b0});
        chk("vec_b1", {24'b0, tx_data[base+1]}, {24'b0, vecs[v].b1});
        chk("vec_spacing", tx_cyc[base+1] - tx_cyc[base], vecs[v].exp_spacing);
      end
      stop_pulse();
      wait_idle(100);
    end

    // Five bytes in IDLE with depth 4: fifth is held until a pop frees a slot
    bytes5[0] = 8'h01; bytes5[1] = 8'h23; bytes5[2] = 8'h45;
    bytes5[3] = 8'h67; bytes5[4] = 8'h89;
    frame_cycles = 16'd2;
    base = tx_data.size();
    for (int i = 0; i < 4; i++) begin
      chk("fill_push_ready", {31'b0, push_ready}, 1);
      push_valid = 1'b1;
      push_data  = bytes5[i];
      tick();
    end
    push_data = bytes5[4];
    chk("full_push_ready", {31'b0, push_ready}, 0);
    tick(); tick();
    chk("full_held", {31'b0, push_ready}, 0);
    start_pulse();
    begin
      int n = 0;
      while (push_ready !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
    end
    chk("slot_freed", {31'b0, push_ready}, 1);
    tick();
    push_valid = 1'b0;
    wait_tx(base + 5, 200);
    for (int i = 0; i < 5; i++)
      if (tx_data.size() > base + i)
        chk("five_order", {24'b0, tx_data[base+i]}, {24'b0, bytes5[i]});
    stop_pulse();
    wait_idle(100);

    // Stop with three bytes queued: drain, then disable
    frame_cycles = 16'd1;
    base = tx_data.size();
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    start_pulse();
    stop_pulse();
    wait_idle(200);
    chk("drain_count", tx_data.size() - base, 3);
    if (tx_data.size() >= base + 3) begin
      chk("drain_b0", {24'b0, tx_data[base]}, 32'hA1);
      chk("drain_b1", {24'b0, tx_data[base+1]}, 32'hB2);
      chk("drain_b2", {24'b0, tx_data[base+2]}, 32'hC3);
      chk("drain_dis_addr", {30'b0, wr_addr[wr_addr.size()-1]}, 1);
      chk("drain_dis_data", {24'b0, wr_data[wr_data.size()-1]}, 0);
      chk("drain_dis_after_tx", {31'b0, wr_cyc[wr_cyc.size()-1] > tx_cyc[tx_cyc.size()-1]}, 1);
    end

    // Stop in IDLE is ignored: a later session must not disable on its own
    stop_pulse();
    start_pulse();
    for (int i = 0; i < 20; i++) tick();
    chk("idle_stop_ignored", {31'b0, busy}, 1);
    stop_pulse();
    wait_idle(100);

    // Reset during GAP
    frame_cycles = 16'd10;
    base = tx_data.size();
    push_byte(8'h5A); push_byte(8'hA5);
    start_pulse();
    wait_tx(base + 1, 50);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_we", {31'b0, we}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_push_ready", {31'b0, push_ready}, 1);
    tick(); tick();
    rst = 1'b1;
    wbase = wr_addr.size();
    for (int i = 0; i < 30; i++) tick();
    chk("post_rst_no_writes", wr_addr.size(), wbase);

    // Randomized streaming against an occupancy/order model
    frame_cycles = GW'($urandom_range(0, 3));
    base = tx_data.size();
    acc = 0;
    model_q.delete();
    start_pulse();
    for (int i = 0; i < 200; i++) begin
      occ = acc - (tx_data.size() - base);
      chk("rand_push_ready", {31'b0, push_ready}, (occ < DEPTH) ? 32'd1 : 32'd0);
      push_valid = 1'($urandom_range(0, 1));
      push_data  = 8'($urandom);
      if (push_valid && push_ready) begin
        model_q.push_back(push_data);
        acc++;
      end
      tick();
    end
    push_valid = 1'b0;
    stop_pulse();
    wait_idle(3000);
    chk("rand_count", tx_data.size() - base, model_q.size());
    for (int i = 0; i < model_q.size(); i++)
      if (tx_data.size() > base + i)
        chk("rand_data", {24'b0, tx_data[base+i]}, {24'b0, model_q[i]});

`ifndef UART_SEQ_RX_POLL_EN
    chk("re_never", re_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, which sets the number of byte entries in the TX holding FIFO.
REQ-002 SHALL have parameter GAP_W, default 16, which sets the width of the inter-byte gap counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins a configure-and-stream session.
REQ-006 SHALL have port stop, input, 1 bit: single-cycle pulse that ends the session after the FIFO drains.
REQ-007 SHALL have port baud_div, input, 8 bits: baud divisor written during configuration.
REQ-008 SHALL have port frame_cycles, input, GAP_W bits: number of clocks to wait after each TX write.
REQ-009 SHALL have ports push_valid (input, 1), push_data (input, 8) and push_ready (output, 1): byte-producer handshake.
REQ-010 SHALL have ports address (output, 2), write_data (output, 8), we (output, 1) and re (output, 1): UART register-bus master.
REQ-011 SHALL have port read_data, input, 8 bits: UART register read value.
REQ-012 SHALL have ports busy (output, 1), rx_data (output, 8) and rx_valid (output, 1).

Function
REQ-013 SHALL implement the FSM states IDLE, CFG_BAUD, CFG_EN, READY, WR_TX, GAP, RX_RD and DIS.
REQ-014 SHALL move IDLE->CFG_BAUD on start, and SHALL ignore start in every other state.
REQ-015 SHALL, in CFG_BAUD, drive address=0, write_data=baud_div and we=1 for one cycle, then go to CFG_EN.
REQ-016 SHALL, in CFG_EN, drive address=1, write_data=8'h01 and we=1 for one cycle, then go to READY.
REQ-017 SHALL, in READY, use this priority: FIFO non-empty -> WR_TX; else stop_pending -> DIS; else (RX poll, REQ-031) -> RX_RD; else stay in READY.
REQ-018 SHALL, in WR_TX, drive address=2, write_data=FIFO head and we=1 for one cycle, pop the FIFO, load the gap counter with max(frame_cycles,1)-1, then go to GAP.
REQ-019 SHALL, in GAP, decrement the counter and go to READY in the cycle after it reads 0; frame_cycles=0 SHALL behave as 1.
REQ-020 SHALL, in DIS, drive address=1, write_data=8'h00 and we=1 for one cycle, then go to IDLE and clear stop_pending.
REQ-021 SHALL latch stop into stop_pending in any non-IDLE state, so the FIFO always drains before DIS; stop in IDLE SHALL be ignored.
REQ-022 SHALL hold we=0, re=0, address=0 and write_data=0 in IDLE, READY and GAP.
REQ-023 SHALL drive busy=1 in every state except IDLE.
REQ-024 SHALL drive push_ready=!full; a push SHALL be accepted whenever push_valid && push_ready, in any state including IDLE.
REQ-025 SHALL, on a simultaneous push and pop while full, reject the push; the freed slot SHALL be visible to push_ready on the next cycle, with no bypass.
REQ-026 SHALL, on a simultaneous push and pop while non-full, keep the occupancy unchanged, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 SHALL drive all bus outputs from registers (Moore outputs, no combinational path from inputs).

Reset
REQ-028 SHALL, on rst low, asynchronously force state=IDLE, clear the FIFO pointers and count, clear stop_pending and the gap counter, and drive we=0, re=0, address=0, write_data=0, busy=0, rx_data=0 and rx_valid=0.
REQ-029 SHALL, on reset mid-session, issue no DIS write; the UART is expected to be reset concurrently.

Configuration
REQ-030 SHALL gate RX polling on the macro UART_SEQ_RX_POLL_EN.
REQ-031 SHALL, with UART_SEQ_RX_POLL_EN defined, go READY->RX_RD when the FIFO is empty and no stop is pending.
REQ-032 SHALL, in RX_RD, drive address=3 and re=1 for one cycle; on the next cycle it SHALL register read_data into rx_data, pulse rx_valid for one cycle and return to READY.
REQ-033 SHALL, without UART_SEQ_RX_POLL_EN, have no RX_RD state, and SHALL tie re=0, rx_data=0 and rx_valid=0.

Structure
REQ-034 SHALL take the register address constants (BAUD_DATA=0, ENABLE=1, TX_DATA=2, RX_DATA=3) and the FSM state encoding from the shared package uart_pkg.
REQ-035 SHALL place the FIFO in the sub-module uart_seq_fifo (parameter FIFO_DEPTH; push/pop/full/empty/head).

Verification
REQ-036 Bench SHALL cover: baud_div=8'h1A, start pulse -> we with addr0/8'h1A, then addr1/8'h01 on the next cycle; busy=1 from the cycle after start.
REQ-037 Bench SHALL cover: push 8'h55, 8'hAA with frame_cycles=5 -> TX writes addr2/8'h55, then addr2/8'hAA, with TX write asserts 7 cycles apart (WR_TX, 5 GAP cycles, READY).
REQ-038 Bench SHALL cover: push 5 bytes while in IDLE with depth 4 -> push_ready=0 after the 4th byte and the 5th byte is held; after start all 5 bytes are sent in order.
REQ-039 Bench SHALL cover: stop asserted with 3 bytes queued -> all 3 TX writes occur, then addr1/8'h00, then IDLE with busy=0.
REQ-040 Bench SHALL cover: rst low during GAP -> same-cycle we=0, busy=0, push_ready=1; no further writes until the next start.
REQ-041 Bench SHALL cover, with UART_SEQ_RX_POLL_EN defined: empty FIFO and read_data=8'h3C -> re pulse at addr3, then rx_valid=1 with rx_data=8'h3C; without the macro, re never asserts.
